pong_score_display: RTL and testbench



---
 rtl/pong_pkg.sv | 64 ++++++
 rtl/bin2bcd_seq.sv | 89 ++++++++
 rtl/pong_score_display.sv | 132 +++++++++++++
 tb/tb_pong_score_display.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// -----------------------------------------------------------------------------
// pong_pkg
//   Definitions shared by the pong score display path:
//     - active-low seven-segment glyphs, bit order {ca,cb,cc,cd,ce,cf,cg}
//     - the state encoding of the sequential binary-to-BCD converter
//     - digit counts for the Nexys4 display and the BCD result
//     - helpers for the double-dabble step and the glyph lookup
// -----------------------------------------------------------------------------
package pong_pkg;

    localparam int NUM_DIGITS = 8;  // anodes on the Nexys4 display
    localparam int BCD_DIGITS = 5;  // 65535 needs five decimal digits

    // Active-low cathodes: a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Double-dabble correction: every nibble that is 5 or more gets +3 so
    // that the following left shift carries correctly into the next digit.
    function automatic logic [19:0] dabble_adjust(input logic [19:0] f);
        logic [19:0] r;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            r[4*i +: 4] = (f[4*i +: 4] >= 4'd5) ? (f[4*i +: 4] + 4'd3)
                                                : f[4*i +: 4];
        end
        return r;
    endfunction

    // Decimal digit to glyph. Anything above 9 cannot come from a valid
    // BCD value and is shown blank rather than as garbage.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
//   Sequential double-dabble converter: 16-bit binary -> 5 BCD digits.
//   One conversion takes 18 cycles from the cycle start is seen in IDLE:
//   1 capture, 16 shift steps, 1 publish.
//
//   Ports
//     clk    in   system clock
//     rst    in   asynchronous active-high reset
//     bin    in   value to convert, sampled when start is seen in IDLE
//     start  in   request a conversion; ignored unless the FSM is in IDLE
//     bcd    out  last completed result, bcd[3:0] = units
//     busy   out  high from the cycle after capture through the DONE cycle
//     state  out  current converter state (conv_state_e encoding)
//
//   Handshake: start is a one-sided request with no ready; the FSM accepts it
//   only in IDLE, and busy low means the next start will be accepted.
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bin,
    input  logic        start,
    output logic [19:0] bcd,
    output logic        busy,
    output logic [1:0]  state
);

    conv_state_e state_q;
    logic [15:0] op_q;
    logic [19:0] field_q;
    logic [3:0]  iter_q;
    logic [19:0] bcd_q;
    logic        busy_q;

    logic [19:0] field_adj_d;

    assign field_adj_d = dabble_adjust(field_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 16'd0;
            field_q <= 20'd0;
            iter_q  <= 4'd0;
            bcd_q   <= 20'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= bin;
                        field_q <= 20'd0;
                        iter_q  <= 4'd0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Shift {field, op} left by one after the +3 correction.
                    // Bit 19 of the adjusted field is always 0 for 16-bit
                    // inputs, so dropping it loses nothing.
                    field_q <= {field_adj_d[18:0], op_q[15]};
                    op_q    <= {op_q[14:0], 1'b0};
                    iter_q  <= iter_q + 4'd1;
                    if (iter_q == 4'd15) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_q   <= field_q;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bcd   = bcd_q;
    assign busy  = busy_q;
    assign state = state_q;

endmodule

// File: rtl/pong_score_display.sv
// -----------------------------------------------------------------------------
// pong_score_display
//   Takes the 16-bit pong score, converts it to BCD whenever it changes and
//   time-multiplexes the digits onto the Nexys4 eight-digit display.
//
//   Parameters
//     SCAN_DIV       clk cycles each digit stays lit (>= 2)
//     BLANK_LEADING  1 blanks leading zeros on digits 4..1
//
//   Ports
//     clk    in   system clock
//     rst    in   asynchronous active-high reset
//     score  in   unsigned binary score, sampled every cycle
//     bcd    out  last converted value, bcd[3:0] = units
//     busy   out  conversion in progress
//     an     out  digit anodes, active-low, an[0] = rightmost
//     ssd    out  cathodes {ca..cg}, active-low
//     dp     out  decimal point, active-low, always off
// -----------------------------------------------------------------------------
module pong_score_display
    import pong_pkg::*;
#(
    parameter int SCAN_DIV      = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    output logic [19:0] bcd,
    output logic        busy,
    output logic [7:0]  an,
    output logic [6:0]  ssd,
    output logic        dp
);

    localparam int            CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

    // ---------------------------------------------------------------------
    // Change detection and conversion
    // ---------------------------------------------------------------------
    logic [15:0] last_bin_q;
    logic [19:0] bcd_w;
    logic        busy_w;
    logic [1:0]  conv_state_w;
    logic        start_w;

    // Only an idle converter accepts a new value, so whatever score is
    // present on the first IDLE cycle is the one converted. Recording
    // last_bin at acceptance is equivalent to recording it at DONE: no
    // comparison is made while the conversion runs, and reset clears both.
    assign start_w = (conv_state_w == IDLE) && (score != last_bin_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_bin_q <= 16'd0;
        end else if (start_w) begin
            last_bin_q <= score;
        end
    end

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .bin   (score),
        .start (start_w),
        .bcd   (bcd_w),
        .busy  (busy_w),
        .state (conv_state_w)
    );

    assign bcd  = bcd_w;
    assign busy = busy_w;

    // ---------------------------------------------------------------------
    // Digit scan
    // ---------------------------------------------------------------------
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 3'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_q <= '0;
            idx_q <= idx_q + 3'd1;  // wraps 7 -> 0 naturally
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Anode / glyph selection. Decoding works only from the published bcd,
    // never from the converter's shift field, so no transient digits show.
    // ---------------------------------------------------------------------
    logic [NUM_DIGITS-1:0] an_d,  an_q;
    logic [6:0]            ssd_d, ssd_q;
    logic [3:0]            nib_d;
    logic                  lead_zero_d;

    always_comb begin
        an_d        = {NUM_DIGITS{1'b1}};
        ssd_d       = SEG_BLANK;
        nib_d       = 4'(bcd_w >> {idx_q, 2'b00});
        // Digit k is a leading zero when it and every digit above it are 0.
        lead_zero_d = (idx_q != 3'd0) && ((bcd_w >> {idx_q, 2'b00}) == 20'd0);
        if (idx_q < 3'(BCD_DIGITS)) begin
            an_d = ~(NUM_DIGITS'(1) << idx_q);
            if ((BLANK_LEADING != 0) && lead_zero_d) begin
                ssd_d = SEG_BLANK;  // anode stays driven, glyph dark
            end else begin
                ssd_d = seg_decode(nib_d);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q  <= 8'b1111_1110;
            ssd_q <= SEG_0;
        end else begin
            an_q  <= an_d;
            ssd_q <= ssd_d;
        end
    end

    assign an  = an_q;
    assign ssd = ssd_q;
    assign dp  = 1'b1;

endmodule

// File: tb/tb_pong_score_display.sv
// -----------------------------------------------------------------------------
// tb_pong_score_display
//   Directed bench: a table of score -> expected BCD vectors, then hand
//   sequences for reset, change-while-busy, display scan/blanking and reset
//   in the middle of a conversion. SCAN_DIV is shortened to 4.
// -----------------------------------------------------------------------------
module tb_pong_score_display;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] GB = 7'b1111111;

    logic        clk;
    logic        rst;
    logic [15:0] score;
    logic [19:0] bcd;
    logic        busy;
    logic [7:0]  an;
    logic [6:0]  ssd;
    logic        dp;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] score;
        logic [19:0] exp_bcd;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] exp_an[8];
    logic [6:0] exp_ssd[8];

    pong_score_display #(
        .SCAN_DIV      (4),
        .BLANK_LEADING (1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .score (score),
        .bcd   (bcd),
        .busy  (busy),
        .an    (an),
        .ssd   (ssd),
        .dp    (dp)
    );

    // ---- clock -----------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- helpers ---------------------------------------------------------
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a new score with the converter idle and follow it through.
    task automatic convert(input logic [15:0] s, input logic [19:0] exp_bcd);
        logic [19:0] old_bcd;
        logic        busy_all;
        old_bcd  = bcd;
        busy_all = 1'b1;
        score    = s;
        for (int k = 1; k <= 17; k++) begin
            step(1);
            if (busy !== 1'b1) busy_all = 1'b0;
        end
        check("busy_n1_to_n17", 32'(busy_all), 32'd1);
        check("bcd_held_n17", 32'(bcd), 32'(old_bcd));
        step(1);
        check("busy_low_n18", 32'(busy), 32'd0);
        check("bcd_n18", 32'(bcd), 32'(exp_bcd));
    endtask

    // Align on the first cycle that digit 0 is lit, then walk all 8 slots,
    // checking the first and last cycle of each 4-cycle window.
    task automatic scan_check(input string tag);
        int  n;
        bit  ok;
        ok = 1'b0;
        n  = 0;
        while (an !== 8'hFF && n < 64) begin step(1); n++; end
        n = 0;
        while (an !== 8'hFE && n < 16) begin step(1); n++; end
        if (an === 8'hFE) ok = 1'b1;
        check({tag, "_sync"}, 32'(ok), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_an%0d", tag, k), 32'(an), 32'(exp_an[k]));
            check($sformatf("%s_ssd%0d", tag, k), 32'(ssd), 32'(exp_ssd[k]));
            step(3);
            check($sformatf("%s_an%0d_end", tag, k), 32'(an), 32'(exp_an[k]));
            step(1);
        end
    endtask

    // ---- stimulus --------------------------------------------------------
    initial begin
        vecs[0] = '{16'd1234,  20'h01234};
        vecs[1] = '{16'd65535, 20'h65535};
        vecs[2] = '{16'd9,     20'h00009};
        vecs[3] = '{16'd10,    20'h00010};
        vecs[4] = '{16'd1000,  20'h01000};
        vecs[5] = '{16'd40000, 20'h40000};
        vecs[6] = '{16'd0,     20'h00000};

        rst   = 1'b1;
        score = 16'd0;
        step(2);
        check("rst_an",   32'(an),   32'hFE);
        check("rst_ssd",  32'(ssd),  32'(G0));
        check("rst_bcd",  32'(bcd),  32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_dp",   32'(dp),   32'h1);
        rst = 1'b0;
        step(3);
        check("zero_no_start", 32'(busy), 32'h0);

        for (int i = 0; i < 7; i++) begin
            convert(vecs[i].score, vecs[i].exp_bcd);
        end

        // Change while busy: 200 arrives at N+5 and is only picked up once
        // the converter is back in IDLE at N+18.
        score = 16'd100;
        step(5);
        score = 16'd200;
        step(13);
        check("chg_bcd_n18", 32'(bcd), 32'h00100);
        check("chg_busy_n18", 32'(busy), 32'h0);
        step(17);
        check("chg_bcd_n35", 32'(bcd), 32'h00100);
        check("chg_busy_n35", 32'(busy), 32'h1);
        step(1);
        check("chg_bcd_n36", 32'(bcd), 32'h00200);

        // Scan and blanking with 1234.
        convert(16'd1234, 20'h01234);
        exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hFF, 8'hFF, 8'hFF};
        exp_ssd = '{G4, G3, G2, G1, GB, GB, GB, GB};
        scan_check("scan1234");

        // Single digit: everything above the units is blanked.
        convert(16'd5, 20'h00005);
        exp_ssd = '{G5, GB, GB, GB, GB, GB, GB, GB};
        scan_check("scan5");

        // Reset eight cycles into a conversion of 42.
        score = 16'd42;
        step(8);
        check("mid_busy_before_rst", 32'(busy), 32'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_an",   32'(an),   32'hFE);
        check("mid_rst_ssd",  32'(ssd),  32'(G0));
        check("mid_rst_bcd",  32'(bcd),  32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        step(2);
        check("mid_rst_hold_bcd", 32'(bcd), 32'h0);
        rst = 1'b0;
        step(1);
        check("post_rst_busy", 32'(busy), 32'h1);
        step(16);
        check("post_rst_bcd_held", 32'(bcd), 32'h0);
        step(1);
        check("post_rst_bcd", 32'(bcd), 32'h00042);
        check("post_rst_busy_low", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
